sti_rx: RTL and testbench
=========================

STI_RX -- requirements
Module: sti_rx

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port si_data, input, 1 bit: serial data bit, valid when si_valid=1.
REQ-004 SHALL have port si_valid, input, 1 bit: a frame is one contiguous run of si_valid=1 cycles.
REQ-005 SHALL have port cfg_length, input, 2 bits: frame length L = 8*(cfg_length+1) bits, sampled at frame start.
REQ-006 SHALL have port cfg_msb, input, 1 bit: 1 = first bit is word MSB; 0 = first bit is word bit 0; sampled at frame start.
REQ-007 SHALL have port mem_ready, input, 1 bit: downstream memory accepts a write this cycle.
REQ-008 SHALL have port rx_word, output, 32 bits: last correctly received word, zero-extended above L.
REQ-009 SHALL have port rx_word_valid, output, 1 bit: one-cycle pulse when rx_word updates.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame closes with bit count != L.
REQ-011 SHALL have port mem_wr, output, 1 bit: registered write strobe.
REQ-012 SHALL have port mem_addr, output, 5 bits: byte address of the current write.
REQ-013 SHALL have port mem_data, output, 8 bits: byte being written.
REQ-014 SHALL have port ovf, output, 1 bit: sticky byte-buffer overflow flag.

Function
REQ-015 SHALL implement FSM states IDLE and RECV; IDLE->RECV on si_valid=1, capturing that bit as bit 1 and latching cfg_length/cfg_msb.
REQ-016 SHALL, in RECV with si_valid=1, capture the bit and increment a 6-bit bit counter saturating at 33; bits beyond L SHALL NOT alter the word or bytes.
REQ-017 SHALL, in RECV with si_valid=0, return to IDLE and, on the same edge, pulse rx_word_valid and load rx_word if count==L, else pulse frame_err and leave rx_word unchanged.
REQ-018 SHALL assemble the word by shifting left when cfg_msb=1 (first bit ends at bit L-1), or by placing the k-th bit at index k-1 when cfg_msb=0.
REQ-019 SHALL assemble bytes in arrival order, first bit of each byte into bit 7, independent of cfg_msb.
REQ-020 SHALL push each byte into a 4-entry FIFO on the edge capturing its 8th bit; partial bytes are discarded at frame close; bytes already pushed from an errored frame are retained.
REQ-021 SHALL, on each edge where the FIFO is non-empty and mem_ready=1, pop one byte and register mem_wr=1 with mem_data set to that byte; otherwise mem_wr=0.
REQ-022 SHALL set mem_addr to the current write pointer during each write and then increment the pointer, wrapping 31->0.
REQ-023 SHALL complete a push and a pop on the same edge when the FIFO is full; a push when full without a pop SHALL drop the byte and set ovf.
REQ-024 SHALL provide latency as follows: 8th bit at edge t gives mem_wr=1 after edge t+1 when mem_ready=1.
REQ-025 SHALL accept a new frame from IDLE in the cycle immediately after a close; a minimum gap of one si_valid=0 cycle between frames applies.

Reset
REQ-026 SHALL, on reset, force state IDLE, counters and FIFO pointers to 0, and rx_word, rx_word_valid, frame_err, mem_wr, mem_addr, mem_data and ovf to 0.
REQ-027 SHALL, on reset mid-frame, abandon the frame without generating rx_word_valid or frame_err pulses.

Structure
REQ-028 SHALL take FSM state encoding, FIFO depth (4), address width (5) and maximum frame bits (32) from a shared package, sti_pkg.
REQ-029 SHALL implement the byte buffer as sub-module sti_rx_fifo (8-bit, 4-deep, synchronous, with full and empty flags).

Verification
REQ-030 SHALL verify: cfg_length=0, cfg_msb=1, bits 1,1,0,0,0,0,0,0 -> rx_word=0x000000C0, rx_word_valid pulse, mem_wr with addr 0 and data 0xC0.
REQ-031 SHALL verify: the same bits with cfg_msb=0 -> rx_word=0x00000003, mem_data=0xC0.
REQ-032 SHALL verify: cfg_length=3, cfg_msb=1, 32 bits of 0x12345678 -> rx_word=0x12345678, bytes 0x12, 0x34, 0x56, 0x78 at addrs 0-3.
REQ-033 SHALL verify: a 12-bit frame with cfg_length=1 -> frame_err pulse, rx_word unchanged, one byte written, partial byte dropped.
REQ-034 SHALL verify: mem_ready=0 with a 32-bit frame followed by a 16-bit frame -> 4 bytes buffered, 2 dropped, ovf=1; then mem_ready=1 -> 4 writes.
REQ-035 SHALL verify: 33 one-byte frames with mem_ready=1 -> mem_addr runs 0..31 then 0; reset asserted mid-frame -> all outputs 0, no pulses.

Source files
------------

// File: rtl/sti_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sti_pkg
//  Brief    : Shared constants and helpers for the serial-to-word receiver.
//  Revision : 1.0  initial release
// ============================================================================
package sti_pkg;

    localparam int c_fifo_depth = 4;
    localparam int c_addr_w     = 5;
    localparam int c_max_bits   = 32;
    localparam int c_cnt_w      = 6;
    localparam int c_state_w    = 1;

    localparam logic [c_cnt_w-1:0]   c_cnt_sat = 6'd33;

    localparam logic [c_state_w-1:0] c_st_idle = 1'b0;
    localparam logic [c_state_w-1:0] c_st_recv = 1'b1;

    // Frame length in bits: 8 * (cfg_length + 1).
    function automatic logic [c_cnt_w-1:0] frame_bits(input logic [1:0] len);
        return {1'b0, len, 3'b000} + 6'd8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sti_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sti_rx_fifo
//  Brief    : Synchronous byte FIFO; a write while full succeeds only when a
//             read happens on the same edge.
//  Revision : 1.0  initial release
// ============================================================================
module sti_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_rd;
    logic             w_do_wr;

    // Pointers carry one extra wrap bit to distinguish full from empty.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_do_rd   = i_rd_en & ~o_empty;
    assign w_do_wr   = i_wr_en & (~o_full | w_do_rd);
    assign o_rd_data = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[c_aw-1:0]] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/sti_rx.sv
`default_nettype none
// ============================================================================
//  Module   : sti_rx
//  Brief    : Serial frame receiver: assembles 8..32-bit words and streams
//             the received bytes to memory through a small byte FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module sti_rx
    import sti_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                si_data,
    input  logic                si_valid,
    input  logic [1:0]          cfg_length,
    input  logic                cfg_msb,
    input  logic                mem_ready,
    output logic [31:0]         rx_word,
    output logic                rx_word_valid,
    output logic                frame_err,
    output logic                mem_wr,
    output logic [c_addr_w-1:0] mem_addr,
    output logic [7:0]          mem_data,
    output logic                ovf
);

    logic [c_state_w-1:0]  r_state;
    logic [c_state_w-1:0]  w_next_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_cnt_w-1:0]    r_len;
    logic                  r_msb;
    logic [c_max_bits-1:0] r_word;
    logic [6:0]            r_byte;
    logic [c_addr_w-1:0]   r_wr_addr;

    logic                  w_start;
    logic                  w_capture;
    logic                  w_close;
    logic                  w_in_range;
    logic                  w_msb;
    logic [c_max_bits-1:0] w_word_base;
    logic [c_max_bits-1:0] w_word_next;
    logic [4:0]            w_bit_idx;
    logic                  w_push;
    logic [7:0]            w_push_data;
    logic                  w_pop;
    logic [7:0]            w_fifo_data;
    logic                  w_full;
    logic                  w_empty;

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (si_valid)  w_next_state = c_st_recv;
            c_st_recv: if (!si_valid) w_next_state = c_st_idle;
            default:                  w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        w_start   = 1'b0;
        w_capture = 1'b0;
        w_close   = 1'b0;
        case (r_state)
            c_st_idle: w_start = si_valid;
            c_st_recv: begin
                w_capture = si_valid;
                w_close   = ~si_valid;
            end
            default: ;
        endcase
    end

    // On the first bit the word restarts from zero using the live config.
    assign w_msb       = w_start ? cfg_msb : r_msb;
    assign w_word_base = w_start ? '0 : r_word;
    assign w_bit_idx   = w_start ? 5'd0 : r_cnt[4:0];
    assign w_in_range  = w_start | (w_capture & (r_cnt < r_len));
    assign w_push      = w_capture & (r_cnt < r_len) & (r_cnt[2:0] == 3'd7);
    assign w_push_data = {r_byte, si_data};
    assign w_pop       = mem_ready & ~w_empty;

    always_comb begin
        w_word_next = w_word_base;
        if (w_msb) w_word_next = {w_word_base[c_max_bits-2:0], si_data};
        else       w_word_next[w_bit_idx] = si_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= '0;
            r_len         <= '0;
            r_msb         <= 1'b0;
            r_word        <= '0;
            r_byte        <= '0;
            r_wr_addr     <= '0;
            rx_word       <= '0;
            rx_word_valid <= 1'b0;
            frame_err     <= 1'b0;
            mem_wr        <= 1'b0;
            mem_addr      <= '0;
            mem_data      <= '0;
            ovf           <= 1'b0;
        end else begin
            rx_word_valid <= 1'b0;
            frame_err     <= 1'b0;

            if (w_start) begin
                r_cnt <= 6'd1;
                r_len <= frame_bits(cfg_length);
                r_msb <= cfg_msb;
            end else if (w_capture && r_cnt != c_cnt_sat) begin
                r_cnt <= r_cnt + 6'd1;
            end

            if (w_in_range) begin
                r_word <= w_word_next;
                r_byte <= w_start ? {6'd0, si_data} : {r_byte[5:0], si_data};
            end

            if (w_close) begin
                if (r_cnt == r_len) begin
                    rx_word       <= r_word;
                    rx_word_valid <= 1'b1;
                end else begin
                    frame_err     <= 1'b1;
                end
            end

            mem_wr <= w_pop;
            if (w_pop) begin
                mem_data  <= w_fifo_data;
                mem_addr  <= r_wr_addr;
                r_wr_addr <= r_wr_addr + 5'd1;
            end

            if (w_push && w_full && !w_pop) ovf <= 1'b1;
        end
    end

    sti_rx_fifo #(
        .WIDTH (8),
        .DEPTH (c_fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_push),
        .i_wr_data (w_push_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_sti_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sti_rx
//  Brief    : Directed self-checking bench for the serial frame receiver.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sti_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        si_data;
    logic        si_valid;
    logic [1:0]  cfg_length;
    logic        cfg_msb;
    logic        mem_ready;
    logic [31:0] rx_word;
    logic        rx_word_valid;
    logic        frame_err;
    logic        mem_wr;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        ovf;

    sti_rx dut (
        .clk           (clk),
        .reset         (reset),
        .si_data       (si_data),
        .si_valid      (si_valid),
        .cfg_length    (cfg_length),
        .cfg_msb       (cfg_msb),
        .mem_ready     (mem_ready),
        .rx_word       (rx_word),
        .rx_word_valid (rx_word_valid),
        .frame_err     (frame_err),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .ovf           (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [4:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];
    int         n_valid = 0;
    int         n_err   = 0;

    always @(negedge clk) begin
        if (mem_wr) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
            wc.push_back(cyc);
        end
        if (rx_word_valid) n_valid++;
        if (frame_err)     n_err++;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int last8_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] qa(input int idx);
        return (idx < wa.size()) ? {27'd0, wa[idx]} : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] qd(input int idx);
        return (idx < wd.size()) ? {24'd0, wd[idx]} : 32'hxxxxxxxx;
    endfunction

    // Sends n bits of 'bits', most significant first; config is scrambled
    // after the first bit to confirm it is latched at frame start.
    task automatic send(input logic [31:0] bits, input int n, input logic [1:0] len,
                        input logic msb, input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            si_valid = 1'b1;
            si_data  = bits[n-1-i];
            if (i == 0) begin
                cfg_length = len;
                cfg_msb    = msb;
            end else if (i == 1) begin
                cfg_length = ~len;
                cfg_msb    = ~msb;
            end
            if (i == 7) last8_cyc = cyc;
        end
        @(negedge clk);
        si_valid = 1'b0;
        si_data  = 1'b0;
        for (int i = 1; i < gap; i++) @(negedge clk);
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        si_valid = 1'b0;
        si_data  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    int base, vbase, ebase;
    logic [7:0] exp_b[4];

    initial begin
        reset = 1'b1; si_valid = 1'b0; si_data = 1'b0;
        cfg_length = 2'd0; cfg_msb = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_rx_word", rx_word, 32'h0);
        chk("rst_valid", {31'd0, rx_word_valid}, 32'h0);
        chk("rst_err", {31'd0, frame_err}, 32'h0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
        chk("rst_mem_addr", {27'd0, mem_addr}, 32'h0);
        chk("rst_mem_data", {24'd0, mem_data}, 32'h0);
        chk("rst_ovf", {31'd0, ovf}, 32'h0);

        // 8-bit frame, MSB first
        base = wd.size(); vbase = n_valid; ebase = n_err;
        send(32'hC0, 8, 2'd0, 1'b1, 1);
        idle(4);
        chk("a_rx_word", rx_word, 32'h0000_00C0);
        chk("a_valid_pulses", n_valid - vbase, 1);
        chk("a_err_pulses", n_err - ebase, 0);
        chk("a_writes", wd.size() - base, 1);
        chk("a_addr", qa(base), 32'h0);
        chk("a_data", qd(base), 32'hC0);
        chk("a_latency", (base < wc.size()) ? wc[base] : -1, last8_cyc + 2);

        // Same bits, LSB first: word changes, byte does not
        base = wd.size(); vbase = n_valid;
        send(32'hC0, 8, 2'd0, 1'b0, 1);
        idle(4);
        chk("b_rx_word", rx_word, 32'h0000_0003);
        chk("b_valid_pulses", n_valid - vbase, 1);
        chk("b_addr", qa(base), 32'h1);
        chk("b_data", qd(base), 32'hC0);

        // 32-bit frame from fresh reset
        do_reset();
        base = wd.size(); vbase = n_valid;
        send(32'h1234_5678, 32, 2'd3, 1'b1, 1);
        idle(4);
        chk("c_rx_word", rx_word, 32'h1234_5678);
        chk("c_valid_pulses", n_valid - vbase, 1);
        chk("c_writes", wd.size() - base, 4);
        exp_b[0] = 8'h12; exp_b[1] = 8'h34; exp_b[2] = 8'h56; exp_b[3] = 8'h78;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("c_addr%0d", k), qa(base + k), k);
            chk($sformatf("c_data%0d", k), qd(base + k), {24'd0, exp_b[k]});
        end

        // Short frame: 12 bits where 16 expected
        base = wd.size(); vbase = n_valid; ebase = n_err;
        send(32'h0000_0A5F, 12, 2'd1, 1'b1, 1);
        idle(4);
        chk("d_err_pulses", n_err - ebase, 1);
        chk("d_valid_pulses", n_valid - vbase, 0);
        chk("d_rx_word", rx_word, 32'h1234_5678);
        chk("d_writes", wd.size() - base, 1);
        chk("d_addr", qa(base), 32'h4);
        chk("d_data", qd(base), 32'hA5);

        // Overflow: memory stalled, 6 bytes into a 4-deep buffer
        mem_ready = 1'b0;
        base = wd.size();
        send(32'hDEAD_BEEF, 32, 2'd3, 1'b1, 1);
        send(32'h0000_CAFE, 16, 2'd1, 1'b1, 1);
        idle(3);
        chk("e_ovf", {31'd0, ovf}, 32'h1);
        chk("e_stalled_writes", wd.size() - base, 0);
        chk("e_rx_word", rx_word, 32'h0000_CAFE);
        mem_ready = 1'b1;
        idle(6);
        chk("e_writes", wd.size() - base, 4);
        exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("e_addr%0d", k), qa(base + k), 5 + k);
            chk($sformatf("e_data%0d", k), qd(base + k), {24'd0, exp_b[k]});
        end
        chk("e_ovf_sticky", {31'd0, ovf}, 32'h1);

        // 33 back-to-back one-byte frames: address wraps 31 -> 0
        do_reset();
        chk("f_ovf_cleared", {31'd0, ovf}, 32'h0);
        base = wd.size(); vbase = n_valid;
        for (int i = 0; i < 33; i++) send(i, 8, 2'd0, 1'b1, 1);
        idle(4);
        chk("f_writes", wd.size() - base, 33);
        chk("f_valid_pulses", n_valid - vbase, 33);
        for (int k = 0; k < 33; k++) begin
            chk($sformatf("f_addr%0d", k), qa(base + k), k % 32);
            chk($sformatf("f_data%0d", k), qd(base + k), k);
        end
        chk("f_rx_word", rx_word, 32'h20);

        // Reset in the middle of a frame
        vbase = n_valid; ebase = n_err;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            si_valid = 1'b1; si_data = 1'b1; cfg_length = 2'd0; cfg_msb = 1'b1;
        end
        @(negedge clk);
        reset = 1'b1; si_valid = 1'b0; si_data = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        idle(5);
        chk("g_rx_word", rx_word, 32'h0);
        chk("g_mem_wr", {31'd0, mem_wr}, 32'h0);
        chk("g_mem_addr", {27'd0, mem_addr}, 32'h0);
        chk("g_mem_data", {24'd0, mem_data}, 32'h0);
        chk("g_ovf", {31'd0, ovf}, 32'h0);
        chk("g_valid_pulses", n_valid - vbase, 0);
        chk("g_err_pulses", n_err - ebase, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
